// File: rtl/qspi_ram_arbiter.sv
// Two-port round-robin arbiter that runs QPI PSRAM bursts (command, address, dummy, data).
// Define QSPI_RAM_INIT_EN to send the 0x35 enter-quad command in SPI mode after reset.
module qspi_ram_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int LEN_W     = 8,
    parameter int DUMMY_CYC = 6
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*LEN_W-1:0]  len,
    input  logic [15:0]         wdata,
    output logic [1:0]          grant,
    output logic                wready,
    output logic [7:0]          rdata,
    output logic                rvalid,
    output logic                done,
    output logic                busy,
    output logic                ram_clk,
    output logic                ram_cs_n,
    output logic [3:0]          ram_io_o,
    output logic [3:0]          ram_io_oe,
    input  logic [3:0]          ram_io_i
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;
`ifdef QSPI_RAM_INIT_EN
    localparam logic [2:0] ST_INIT  = 3'd6;
    localparam logic [7:0] CMD_QPI  = 8'h35;
    localparam logic [2:0] ST_RESET = ST_INIT;
`else
    localparam logic [2:0] ST_RESET = ST_IDLE;
`endif
    localparam logic       RST_BUSY = (ST_RESET != ST_IDLE);
    localparam int         CNT_W    = LEN_W + 1;

    logic [2:0]       state_r;
    logic             ph_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      sr_r;
    logic             port_r, last_r, we_r;
    logic [LEN_W-1:0] len_r;
    logic [3:0]       wlo_r, rhi_r;
    logic [1:0]       grant_r;
    logic             wready_r, rvalid_r, done_r, busy_r, ram_clk_r, cs_n_r;
    logic [7:0]       rdata_r;
    logic [3:0]       io_o_r, io_oe_r;

    logic              pick_s, we_sel_s;
    logic [ADDR_W-1:0] addr_sel_s;
    logic [23:0]       addr24_s;
    logic [LEN_W-1:0]  len_sel_s;
    logic [7:0]        cmd_s, wbyte_s;
    logic [CNT_W-1:0]  last_s;

    assign grant     = grant_r;
    assign wready    = wready_r;
    assign rdata     = rdata_r;
    assign rvalid    = rvalid_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign ram_clk   = ram_clk_r;
    assign ram_cs_n  = cs_n_r;
    assign ram_io_o  = io_o_r;
    assign ram_io_oe = io_oe_r;

    // Round-robin winner and selection of its request fields
    always_comb begin
        pick_s = 1'b0;
        if (req == 2'b11) begin
            pick_s = ~last_r;
        end else begin
            pick_s = req[1];
        end
        we_sel_s   = pick_s ? we[1] : we[0];
        addr_sel_s = pick_s ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        len_sel_s  = pick_s ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
        addr24_s   = 24'(addr_sel_s);
        cmd_s      = we_sel_s ? 8'h38 : 8'hEB;
        wbyte_s    = port_r ? wdata[15:8] : wdata[7:0];
        last_s     = {len_r, 1'b1};
    end

    // Transaction sequencer: arbitration, two-cycle nibble engine and handshake pulses
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r   <= ST_RESET;
            ph_r      <= 1'b0;
            cnt_r     <= '0;
            sr_r      <= 32'h0000_0000;
            port_r    <= 1'b0;
            last_r    <= 1'b1;
            we_r      <= 1'b0;
            len_r     <= '0;
            wlo_r     <= 4'h0;
            rhi_r     <= 4'h0;
            grant_r   <= 2'b00;
            wready_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            done_r    <= 1'b0;
            rdata_r   <= 8'h00;
            busy_r    <= RST_BUSY;
            ram_clk_r <= 1'b0;
            cs_n_r    <= 1'b1;
            io_o_r    <= 4'h0;
            io_oe_r   <= 4'h0;
        end else begin
            wready_r <= 1'b0;
            rvalid_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        state_r <= ST_CMD;
                        busy_r  <= 1'b1;
                        grant_r <= pick_s ? 2'b10 : 2'b01;
                        last_r  <= pick_s;
                        port_r  <= pick_s;
                        we_r    <= we_sel_s;
                        len_r   <= len_sel_s;
                        sr_r    <= {cmd_s, addr24_s};
                        io_o_r  <= cmd_s[7:4];
                        io_oe_r <= 4'hF;
                        cs_n_r  <= 1'b0;
                        ph_r    <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_END: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r[0]) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= '0;
                    end
                end
                default: begin
`ifdef QSPI_RAM_INIT_EN
                    if (state_r == ST_INIT && cs_n_r) begin
                        cs_n_r  <= 1'b0;
                        io_oe_r <= 4'b0001;
                        io_o_r  <= {3'b000, CMD_QPI[7]};
                        sr_r    <= {CMD_QPI, 24'h000000};
                    end else
`endif
                    if (!ph_r) begin
                        ph_r      <= 1'b1;
                        ram_clk_r <= 1'b1;
                    end else begin
                        // End of a high phase: RAM has clocked this nibble, present the next one
                        ph_r      <= 1'b0;
                        ram_clk_r <= 1'b0;
                        cnt_r     <= cnt_r + CNT_W'(1);
                        case (state_r)
                            ST_CMD: begin
                                sr_r   <= sr_r << 4;
                                io_o_r <= sr_r[27:24];
                                if (cnt_r == CNT_W'(1)) begin
                                    state_r <= ST_ADDR;
                                    cnt_r   <= '0;
                                end
                            end
                            ST_ADDR: begin
                                sr_r   <= sr_r << 4;
                                io_o_r <= sr_r[27:24];
                                if (cnt_r == CNT_W'(5)) begin
                                    cnt_r <= '0;
                                    if (we_r) begin
                                        state_r  <= ST_DATA;
                                        io_o_r   <= wbyte_s[7:4];
                                        wlo_r    <= wbyte_s[3:0];
                                        wready_r <= 1'b1;
                                    end else begin
                                        state_r <= ST_DUMMY;
                                        io_o_r  <= 4'h0;
                                        io_oe_r <= 4'h0;
                                    end
                                end
                            end
                            ST_DUMMY: begin
                                if (cnt_r == CNT_W'(DUMMY_CYC - 1)) begin
                                    state_r <= ST_DATA;
                                    cnt_r   <= '0;
                                end
                            end
                            ST_DATA: begin
                                if (we_r) begin
                                    if (!cnt_r[0]) begin
                                        io_o_r <= wlo_r;
                                    end else if (cnt_r != last_s) begin
                                        io_o_r   <= wbyte_s[7:4];
                                        wlo_r    <= wbyte_s[3:0];
                                        wready_r <= 1'b1;
                                    end
                                end else if (!cnt_r[0]) begin
                                    rhi_r <= ram_io_i;
                                end else begin
                                    rdata_r  <= {rhi_r, ram_io_i};
                                    rvalid_r <= 1'b1;
                                end
                                if (cnt_r == last_s) begin
                                    state_r <= ST_END;
                                    cnt_r   <= '0;
                                    cs_n_r  <= 1'b1;
                                    io_o_r  <= 4'h0;
                                    io_oe_r <= 4'h0;
                                    grant_r <= 2'b00;
                                    done_r  <= 1'b1;
                                end
                            end
`ifdef QSPI_RAM_INIT_EN
                            ST_INIT: begin
                                sr_r   <= sr_r << 1;
                                io_o_r <= {3'b000, sr_r[30]};
                                if (cnt_r == CNT_W'(7)) begin
                                    state_r <= ST_END;
                                    cnt_r   <= '0;
                                    cs_n_r  <= 1'b1;
                                    io_o_r  <= 4'h0;
                                    io_oe_r <= 4'h0;
                                end
                            end
`endif
                            default: begin
                                state_r <= ST_END;
                                cnt_r   <= '0;
                                cs_n_r  <= 1'b1;
                                io_o_r  <= 4'h0;
                                io_oe_r <= 4'h0;
                                grant_r <= 2'b00;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_ram_arbiter.sv
// Directed bench for qspi_ram_arbiter: table of bursts plus tie, back-to-back and abort sequences.
module tb_qspi_ram_arbiter;
    localparam int DUMMY_CYC = 6;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [47:0] addr = 48'h0;
    logic [15:0] len = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [1:0]  grant;
    logic        wready, rvalid, done, busy, ram_clk, ram_cs_n;
    logic [7:0]  rdata;
    logic [3:0]  ram_io_o, ram_io_oe;
    logic [3:0]  ram_io_i = 4'h0;

    int n_tests = 0;
    int n_fail  = 0;

    qspi_ram_arbiter #(.ADDR_W(24), .LEN_W(8), .DUMMY_CYC(DUMMY_CYC)) dut (
        .clk_in(clk_in), .rst(rst), .req(req), .we(we), .addr(addr), .len(len),
        .wdata(wdata), .grant(grant), .wready(wready), .rdata(rdata), .rvalid(rvalid),
        .done(done), .busy(busy), .ram_clk(ram_clk), .ram_cs_n(ram_cs_n),
        .ram_io_o(ram_io_o), .ram_io_oe(ram_io_oe), .ram_io_i(ram_io_i)
    );

    always #5 clk_in = ~clk_in;

    // RAM model and pin monitor; statistics restart at each cs_n fall
    logic [7:0] model_rd [4];
    logic       cs_prev = 1'b1;
    int         cs_low = 0, wr_cnt = 0, dn_cnt = 0, rise = 0, mon_d = 0;
    logic [3:0] nib_q [$];
    logic [3:0] oe_q [$];
    logic [7:0] rd_q [$];

    always @(negedge clk_in) begin
        if (!ram_cs_n && cs_prev) begin
            cs_low = 0; wr_cnt = 0; dn_cnt = 0; rise = 0;
            nib_q.delete(); oe_q.delete(); rd_q.delete();
        end
        cs_prev = ram_cs_n;
        if (!ram_cs_n) cs_low++;
        if (wready) wr_cnt++;
        if (rvalid) rd_q.push_back(rdata);
        if (done) dn_cnt++;
        if (!ram_cs_n && ram_clk) begin
            oe_q.push_back(ram_io_oe);
            if (ram_io_oe == 4'hF) nib_q.push_back(ram_io_o);
            mon_d = rise - 8 - DUMMY_CYC;
            if (mon_d >= 0 && mon_d < 8)
                ram_io_i = (mon_d % 2 == 0) ? model_rd[mon_d/2][7:4] : model_rd[mon_d/2][3:0];
            else
                ram_io_i = 4'h0;
            rise++;
        end
    end

    typedef struct packed {
        logic        port;
        logic        wr;
        logic [23:0] a;
        logic [7:0]  l;
        logic [31:0] data;
        logic [1:0]  exp_grant;
        logic [15:0] exp_cs;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(posedge clk_in); #1; cyc++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy !== 1'b0 && cyc < 20) begin
            @(posedge clk_in); #1; cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int p, bi, cyc, nerr, nexp_oe;
        logic [7:0] cmd, b;
        logic [3:0] exp_n [$];
        p = v.port ? 1 : 0;
        for (int i = 0; i < 4; i++) model_rd[i] = v.data[31-8*i -: 8];
        @(posedge clk_in); #1;
        we[p] = v.wr; addr[p*24 +: 24] = v.a; len[p*8 +: 8] = v.l;
        wdata[p*8 +: 8] = v.data[31:24]; req[p] = 1'b1;
        @(posedge clk_in); #1;
        check("grant_lat", grant, v.exp_grant);
        req[p] = 1'b0;
        we[p] = ~v.wr; addr[p*24 +: 24] = ~v.a; len[p*8 +: 8] = ~v.l;
        bi = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            if (wready === 1'b1) begin
                bi++;
                if (bi < 4) wdata[p*8 +: 8] = v.data[31-8*bi -: 8];
            end
            @(posedge clk_in); #1; cyc++;
        end
        check("done_seen", done, 1'b1);
        check("done_cs_grant", {ram_cs_n, grant}, {1'b1, 2'b00});
        @(posedge clk_in); #1;
        cmd = v.wr ? 8'h38 : 8'hEB;
        exp_n.push_back(cmd[7:4]); exp_n.push_back(cmd[3:0]);
        for (int i = 5; i >= 0; i--) exp_n.push_back(v.a[4*i +: 4]);
        if (v.wr) begin
            for (int i = 0; i <= int'(v.l); i++) begin
                b = v.data[31-8*i -: 8];
                exp_n.push_back(b[7:4]); exp_n.push_back(b[3:0]);
            end
        end
        check("nib_count", nib_q.size(), exp_n.size());
        nerr = 0;
        for (int i = 0; i < nib_q.size() && i < exp_n.size(); i++)
            if (nib_q[i] !== exp_n[i]) nerr++;
        check("nib_values", nerr, 0);
        check("cs_low_cycles", cs_low, v.exp_cs);
        nexp_oe = v.wr ? 8 + 2*(int'(v.l)+1) : 8 + DUMMY_CYC + 2*(int'(v.l)+1);
        check("ram_clk_rises", oe_q.size(), nexp_oe);
        nerr = 0;
        for (int i = 0; i < oe_q.size(); i++)
            if (oe_q[i] !== ((i < 8 || v.wr) ? 4'hF : 4'h0)) nerr++;
        check("oe_pattern", nerr, 0);
        check("wready_count", wr_cnt, v.wr ? int'(v.l) + 1 : 0);
        check("rvalid_count", rd_q.size(), v.wr ? 0 : int'(v.l) + 1);
        if (!v.wr) begin
            for (int i = 0; i < rd_q.size() && i < 4; i++)
                check("rdata", rd_q[i], v.data[31-8*i -: 8]);
        end
        check("done_count", dn_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, nw, nd, gap;
        vecs[0] = '{1'b1, 1'b1, 24'h123456, 8'd0, 32'hA500_0000, 2'b10, 16'd20};
        vecs[1] = '{1'b0, 1'b0, 24'h000010, 8'd1, 32'h3CD2_0000, 2'b01, 16'd36};
        vecs[2] = '{1'b0, 1'b1, 24'hABCDEF, 8'd3, 32'h1122_3344, 2'b01, 16'd32};
        vecs[3] = '{1'b1, 1'b0, 24'hFFFFFF, 8'd0, 32'h7E00_0000, 2'b10, 16'd32};
        for (int i = 0; i < 4; i++) model_rd[i] = 8'h00;

        #12;
        check("reset_pins", {ram_cs_n, ram_clk, ram_io_oe, ram_io_o, grant},
              {1'b1, 1'b0, 4'h0, 4'h0, 2'b00});
        check("reset_flags", {wready, rvalid, done, busy, rdata}, {1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        @(posedge clk_in); #1; rst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Abort a len-3 write during its second data byte
        @(posedge clk_in); #1;
        we = 2'b01; addr[23:0] = 24'h0000AA; len[7:0] = 8'd3; wdata[7:0] = 8'h11; req = 2'b01;
        cyc = 0; nw = 0;
        while (nw < 2 && cyc < 200) begin
            @(posedge clk_in); #1; cyc++;
            if (wready === 1'b1) begin nw++; wdata[7:0] = wdata[7:0] + 8'h11; end
        end
        check("abort_reach_byte2", nw, 2);
        req = 2'b00;
        @(posedge clk_in); #1;
        rst = 1'b1; #1;
        check("abort_pins", {ram_cs_n, ram_clk, ram_io_oe, grant, done, busy},
              {1'b1, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0});
        @(posedge clk_in); #1; rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
            if (done === 1'b1 || ram_cs_n !== 1'b1) nd++;
        end
        check("abort_quiet", nd, 0);
        run_vec(vecs[0]);

        // Ties and back-to-back requests, starting from a fresh reset
        @(posedge clk_in); #1; rst = 1'b1;
        @(posedge clk_in); #1; rst = 1'b0;
        we = 2'b11; addr = {24'h000200, 24'h000100}; len = 16'h0000; wdata = 16'hC35A;
        req = 2'b11;
        @(posedge clk_in); #1;
        check("tie1_grant", grant, 2'b01);
        req[0] = 1'b0;
        wait_done("tie1_done");
        gap = 0;
        while (grant !== 2'b10 && gap < 20) begin @(posedge clk_in); #1; gap++; end
        check("b2b_gap", gap, 3);
        check("pending_grant", grant, 2'b10);
        req[1] = 1'b0;
        wait_done("pending_done");
        wait_idle();
        req = 2'b11;
        @(posedge clk_in); #1;
        check("tie2_grant", grant, 2'b01);
        req[0] = 1'b0;
        wait_done("tie2_done");
        req[0] = 1'b1;
        gap = 0;
        while (grant === 2'b00 && gap < 20) begin @(posedge clk_in); #1; gap++; end
        check("rereq_grant", grant, 2'b10);
        req = 2'b00;
        wait_done("rereq_done");
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
